// File: rtl/jedro_1_data_mem.sv
// Data RAM responder for the jedro_1 core data port: programmable grant stall, byte-masked
// writes, registered read/error response. Optional macro: JEDRO_1_DMEM_ALIGN_CHECK_EN.
module jedro_1_data_mem #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned GNT_STALL = 0
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        data_req_o,
  output logic        data_gnt_i,
  output logic        data_rvalid_i,
  input  logic        data_we_o,
  input  logic [3:0]  data_be_o,
  input  logic [31:0] data_addr_o,
  input  logic [31:0] data_wdata_o,
  output logic [31:0] data_rdata_i,
  output logic        data_err_i
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  STALL     = 4'(GNT_STALL);

  logic [31:0]      mem_q [MEM_WORDS];
  logic [3:0]       cnt_q, cnt_d;
  logic             rvalid_q, rvalid_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      offset;
  logic [IDX_W-1:0] wordIdx;
  logic             beLegal;
  logic             accErr;
  logic [31:0]      laneMask;
  logic             gnt;

  always_comb begin
    offset  = data_addr_o - BASE_ADDR;
    wordIdx = offset[IDX_W+1:2];
`ifdef JEDRO_1_DMEM_ALIGN_CHECK_EN
    beLegal = data_be_o inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0011, 4'b1100, 4'b1111};
`else
    beLegal = (data_be_o != 4'b0000);
`endif
    accErr = (offset >= MEM_BYTES) || !beLegal;
    for (int n = 0; n < 4; n++) begin
      laneMask[8*n +: 8] = {8{data_be_o[n]}};
    end
    // Grant is suppressed while reset is held so nothing is accepted or written.
    gnt = rstn_i && data_req_o && (cnt_q == STALL);

    cnt_d    = (data_req_o && (cnt_q < STALL)) ? cnt_q + 4'd1 : 4'd0;
    rvalid_d = gnt;
    err_d    = gnt && accErr;
    rdata_d  = (gnt && !data_we_o && !accErr) ? (mem_q[wordIdx] & laneMask) : 32'h0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q    <= 4'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Writes commit on the grant edge so a read granted next cycle already sees them.
  always_ff @(posedge clk_i) begin
    if (gnt && data_we_o && !accErr) begin
      for (int n = 0; n < 4; n++) begin
        if (data_be_o[n]) begin
          mem_q[wordIdx][8*n +: 8] <= data_wdata_o[8*n +: 8];
        end
      end
    end
  end

  assign data_gnt_i    = gnt;
  assign data_rvalid_i = rvalid_q;
  assign data_err_i    = err_q;
  assign data_rdata_i  = rdata_q;

endmodule

// File: tb/tb_jedro_1_data_mem.sv
// Bench for jedro_1_data_mem: one instance with no grant stall, one with a 3-cycle stall,
// both checked every cycle against a memory/response model plus directed literal checks.
module tb_jedro_1_data_mem;

  logic        clk;
  logic        rstn;
  logic        req0, we0, gnt0, rvalid0, err0;
  logic [3:0]  be0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req3, we3, gnt3, rvalid3, err3;
  logic [3:0]  be3;
  logic [31:0] addr3, wdata3, rdata3;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] modelMem   [2][1024];
  logic [3:0]  modelKnown [2][1024];
  logic        pendValid  [2];
  logic        pendErr    [2];
  logic [31:0] pendData   [2];
  logic        pendKnown  [2];
  int          waited     [2];

  jedro_1_data_mem #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_STALL(0)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .data_req_o(req0), .data_gnt_i(gnt0),
    .data_rvalid_i(rvalid0), .data_we_o(we0), .data_be_o(be0), .data_addr_o(addr0),
    .data_wdata_o(wdata0), .data_rdata_i(rdata0), .data_err_i(err0)
  );

  jedro_1_data_mem #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_STALL(3)) dut3 (
    .clk_i(clk), .rstn_i(rstn), .data_req_o(req3), .data_gnt_i(gnt3),
    .data_rvalid_i(rvalid3), .data_we_o(we3), .data_be_o(be3), .data_addr_o(addr3),
    .data_wdata_o(wdata3), .data_rdata_i(rdata3), .data_err_i(err3)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  function automatic bit beOk(input logic [3:0] be);
`ifdef JEDRO_1_DMEM_ALIGN_CHECK_EN
    return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
`else
    return be != 4'b0000;
`endif
  endfunction

  // One cycle of the reference: compare current outputs, then decide what the
  // coming clock edge does to the memory and to next cycle's response.
  task automatic modelCycle(input int d, input int stall, input logic req, input logic we,
                            input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic gnt, input logic rvalid,
                            input logic err, input logic [31:0] rdata);
    logic        expGnt;
    logic        bad;
    logic [31:0] off;
    int          idx;
    string       tag;
    tag = (d == 0) ? "stall0" : "stall3";
    if (!rstn) begin
      checkOutput({tag, " gnt in reset"}, 32'(gnt), 32'h0);
      checkOutput({tag, " rvalid in reset"}, 32'(rvalid), 32'h0);
      checkOutput({tag, " err in reset"}, 32'(err), 32'h0);
      checkOutput({tag, " rdata in reset"}, rdata, 32'h0);
      pendValid[d] = 1'b0;
      pendErr[d]   = 1'b0;
      pendData[d]  = 32'h0;
      pendKnown[d] = 1'b1;
      waited[d]    = 0;
      return;
    end
    expGnt = req && (waited[d] == stall);
    checkOutput({tag, " gnt"}, 32'(gnt), 32'(expGnt));
    checkOutput({tag, " rvalid"}, 32'(rvalid), 32'(pendValid[d]));
    checkOutput({tag, " err"}, 32'(err), 32'(pendErr[d]));
    if (pendKnown[d]) checkOutput({tag, " rdata"}, rdata, pendData[d]);

    pendValid[d] = expGnt;
    pendErr[d]   = 1'b0;
    pendData[d]  = 32'h0;
    pendKnown[d] = 1'b1;
    if (expGnt) begin
      off = addr - 32'h0;
      bad = (off >= 32'd4096) || !beOk(be);
      pendErr[d] = bad;
      if (!bad) begin
        idx = int'(off / 4);
        for (int n = 0; n < 4; n++) begin
          if (be[n]) begin
            if (we) begin
              modelMem[d][idx][8*n +: 8] = wdata[8*n +: 8];
              modelKnown[d][idx][n] = 1'b1;
            end else begin
              pendData[d][8*n +: 8] = modelMem[d][idx][8*n +: 8];
              if (!modelKnown[d][idx][n]) pendKnown[d] = 1'b0;
            end
          end
        end
      end
    end
    waited[d] = (req && !expGnt) ? waited[d] + 1 : 0;
  endtask

  always @(negedge clk) begin
    modelCycle(0, 0, req0, we0, be0, addr0, wdata0, gnt0, rvalid0, err0, rdata0);
    modelCycle(1, 3, req3, we3, be3, addr3, wdata3, gnt3, rvalid3, err3, rdata3);
  end

  // Drives one cycle of inputs just after the rising edge and returns at mid-cycle.
  task automatic applyStimulus(input int d, input logic req, input logic we,
                               input logic [3:0] be, input logic [31:0] addr,
                               input logic [31:0] wdata);
    @(posedge clk);
    #1;
    if (d == 0) begin
      req0 = req; we0 = we; be0 = be; addr0 = addr; wdata0 = wdata;
    end else begin
      req3 = req; we3 = we; be3 = be; addr3 = addr; wdata3 = wdata;
    end
    @(negedge clk);
  endtask

  logic [31:0] vals [4];

  initial begin
    vals = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 1024; i++) begin
        modelMem[d][i]   = 32'h0;
        modelKnown[d][i] = 4'h0;
      end
      pendValid[d] = 1'b0; pendErr[d] = 1'b0; pendData[d] = 32'h0;
      pendKnown[d] = 1'b1; waited[d] = 0;
    end
    clk = 1'b0; rstn = 1'b0;
    req0 = 1'b1; we0 = 1'b0; be0 = 4'hF; addr0 = 32'h10; wdata0 = 32'h0;
    req3 = 1'b0; we3 = 1'b0; be3 = 4'h0; addr3 = 32'h0; wdata3 = 32'h0;

    repeat (2) @(negedge clk);
    checkOutput("reset gnt", 32'(gnt0), 32'h0);
    checkOutput("reset rvalid", 32'(rvalid0), 32'h0);
    checkOutput("reset rdata", rdata0, 32'h0);
    checkOutput("reset err", 32'(err0), 32'h0);
    @(posedge clk); #1; req0 = 1'b0; rstn = 1'b1;

    applyStimulus(0, 1, 1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    checkOutput("write gnt same cycle", 32'(gnt0), 32'h1);
    applyStimulus(0, 1, 0, 4'hF, 32'h10, 32'h0);
    checkOutput("read gnt", 32'(gnt0), 32'h1);
    checkOutput("write rvalid", 32'(rvalid0), 32'h1);
    checkOutput("write rdata zero", rdata0, 32'h0);
    applyStimulus(0, 1, 1, 4'b0100, 32'h12, 32'h00AA_0000);
    checkOutput("raw rdata", rdata0, 32'hDEAD_BEEF);
    checkOutput("raw err", 32'(err0), 32'h0);
    applyStimulus(0, 1, 0, 4'hF, 32'h10, 32'h0);
    applyStimulus(0, 1, 0, 4'b0011, 32'h10, 32'h0);
    checkOutput("byte write merge", rdata0, 32'hDEAA_BEEF);
    applyStimulus(0, 1, 0, 4'hF, 32'h1000, 32'h0);
    checkOutput("half read lanes", rdata0, 32'h0000_BEEF);
    applyStimulus(0, 1, 1, 4'hF, 32'h1000, 32'h1234_5678);
    checkOutput("oob read err", 32'(err0), 32'h1);
    checkOutput("oob read rdata", rdata0, 32'h0);
    applyStimulus(0, 1, 1, 4'b0000, 32'h10, 32'hFFFF_FFFF);
    checkOutput("oob write err", 32'(err0), 32'h1);
    applyStimulus(0, 1, 1, 4'b0110, 32'h10, 32'h1122_3344);
    checkOutput("be zero err", 32'(err0), 32'h1);
    applyStimulus(0, 1, 0, 4'hF, 32'h10, 32'h0);
`ifdef JEDRO_1_DMEM_ALIGN_CHECK_EN
    checkOutput("be 0110 err", 32'(err0), 32'h1);
`else
    checkOutput("be 0110 err", 32'(err0), 32'h0);
`endif
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0);
`ifdef JEDRO_1_DMEM_ALIGN_CHECK_EN
    checkOutput("be 0110 result", rdata0, 32'hDEAA_BEEF);
`else
    checkOutput("be 0110 result", rdata0, 32'hDE22_33EF);
`endif

    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 4'hF, 32'h20 + 32'(4 * i), vals[i]);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 4'hF, 32'h20 + 32'(4 * i), 32'h0);
      checkOutput("b2b rvalid", 32'(rvalid0), 32'h1);
      if (i > 0) checkOutput("b2b rdata", rdata0, vals[i-1]);
    end
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("b2b last rdata", rdata0, vals[3]);

    applyStimulus(0, 1, 0, 4'hF, 32'h20, 32'h0);
    applyStimulus(0, 1, 0, 4'hF, 32'h24, 32'h0);
    applyStimulus(0, 1, 0, 4'hF, 32'h28, 32'h0);
    checkOutput("pre-reset rdata", rdata0, vals[1]);
    #2 rstn = 1'b0;
    #1;
    checkOutput("async reset gnt", 32'(gnt0), 32'h0);
    checkOutput("async reset rvalid", 32'(rvalid0), 32'h0);
    checkOutput("async reset rdata", rdata0, 32'h0);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1; rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0);
      checkOutput("no response after reset", 32'(rvalid0), 32'h0);
    end

    for (int c = 0; c < 4; c++) begin
      applyStimulus(1, 1, 1, 4'hF, 32'h40, 32'hCAFE_F00D);
      checkOutput("stall write gnt", 32'(gnt3), (c == 3) ? 32'h1 : 32'h0);
    end
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1, 1, 0, 4'hF, (c == 3) ? 32'h40 : 32'h44, 32'h0);
      checkOutput("stall read gnt", 32'(gnt3), (c == 3) ? 32'h1 : 32'h0);
      checkOutput("stall rvalid", 32'(rvalid3), (c == 0) ? 32'h1 : 32'h0);
    end
    applyStimulus(1, 0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("stall read rvalid", 32'(rvalid3), 32'h1);
    checkOutput("stall read rdata", rdata3, 32'hCAFE_F00D);
    applyStimulus(1, 0, 0, 4'h0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/jedro_1_data_mem.md
Name: jedro_1_data_mem

Overview:
Data-memory responder on the far end of the core's data interface (req/gnt/rvalid handshake, byte enables, error flag). It grants requests, optionally after a programmable stall, and performs byte-masked writes to an internal word array. It returns read data or an error response one cycle after grant, and sits beside the core in simulation and FPGA top levels as its data RAM.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the array (power of two, >= 4)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (MEM_WORDS*4 aligned)
GNT_STALL, 0, cycles gnt is held low after req first seen (0..15)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rstn_i  input  1  reset; asynchronous, active-low
data_req_o  input  1  request from core; addr/we/be/wdata valid while high
data_gnt_i  output  1  request accepted this cycle
data_rvalid_i  output  1  response valid (one cycle per granted request)
data_we_o  input  1  1 = write, 0 = read
data_be_o  input  4  byte enables, bit n = byte lane n
data_addr_o  input  32  byte address
data_wdata_o  input  32  write data, lane-aligned
data_rdata_i  output  32  read data
data_err_i  output  1  error response, valid with rvalid

Port names match the core's side of the interface. Directions are stated from this block's view.

Behaviour:
- Reset (async assert, sync-released by the system): gnt=0, rvalid=0, rdata=0, err=0, stall counter=0. Array contents not reset. A response pending at reset is discarded.
- Grant: stall counter cnt (4 bit).
  - gnt = req && (cnt == GNT_STALL), combinational.
  - Each cycle req && cnt<GNT_STALL: cnt <= cnt+1.
  - Grant cycle: cnt <= 0.
  - req low: cnt <= 0.
  - GNT_STALL=0 gives same-cycle grant.
- Access check at grant:
  - off = addr - BASE_ADDR.
  - Error if off >= MEM_WORDS*4, or be == 4'b0000.
  - Word index = off[log2(MEM_WORDS)+1:2]. addr[1:0] is ignored for indexing.
- Write (grant, we=1, no error): for each set be[n], mem[idx] byte n <= wdata byte n on the grant edge. Other bytes unchanged.
- Read (grant, we=0, no error): rdata registered next cycle = mem[idx] with non-enabled lanes forced to 0.
- Response: rvalid=1 exactly one cycle after each grant cycle, for one cycle.
  - err=1 on error; rdata=0 on error and on all writes.
  - When rvalid=0: rdata and err hold 0.
- Pipelining: one new grant per cycle allowed (GNT_STALL=0), so back-to-back requests give back-to-back rvalid.
- Read-after-write: a read granted the cycle after a write to the same word returns the new data, because the write commits on the grant edge.
- Ordering: responses in grant order; at most one response in flight per cycle.
- Address/data changes while req high and not granted: the values in the grant cycle are used.

Optional Feature:
Macro JEDRO_1_DMEM_ALIGN_CHECK_EN.
- Defined: be must be a naturally aligned pattern, one of 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other non-zero be (e.g. 0110, 0111, 1011) gives an error response, with no write and rdata=0.
- Undefined: any non-zero be is legal and applied lane-wise. be==0 still errors.

Test Plan:
- GNT_STALL=0: write addr 0x10, be 1111, wdata 0xDEADBEEF; next cycle read 0x10 -> gnt same cycle as req; rvalid one cycle after each grant; read rdata=0xDEADBEEF, err=0.
- Byte write addr 0x12, be 0100, wdata 0x00AA0000 onto 0xDEADBEEF, then read be 1111 -> rdata=0xDEAABEEF. Read be 0011 -> rdata=0x0000BEEF.
- GNT_STALL=3, req held high from cycle 0 -> gnt=1 only in cycle 3; rvalid in cycle 4; next request again stalls 3 cycles.
- Read at addr MEM_WORDS*4 (0x1000 for defaults) -> gnt normal, rvalid with err=1, rdata=0. Write there -> err=1, array unchanged. be=0000 -> err=1.
- Four back-to-back reads, req high for 4 cycles, GNT_STALL=0 -> four consecutive rvalid pulses, data in order. Assert rstn_i low in the cycle after the 2nd grant -> rvalid/gnt/rdata/err drop to 0 immediately; no further responses after release.
- With JEDRO_1_DMEM_ALIGN_CHECK_EN: write be 0110 -> err=1, memory unchanged. Without the macro: same write -> err=0, lanes 1 and 2 updated.
